keypad_entry_controller: RTL and testbench
==========================================

Name: keypad_entry_controller

Overview:
- Scans a 4x4 hex keypad, debounces it, and sequences digit entry into two 16-bit operand registers (num1, num2).
- Sits between the board keypad pins and the downstream arithmetic/display logic.
- Replaces ad-hoc per-switch digit capture with one key-driven entry sequencer: each accepted key shifts in one hex digit; the 4th digit commits the operand.

Parameters:
- SETTLE_CYCLES, 100000, cycles each column is driven before its row sample (1 ms at 100 MHz); minimum 2.
- DEBOUNCE_SWEEPS, 4, consecutive identical full sweeps needed to accept a press or a release; minimum 1.

Ports:
- clk  in  1  system clock, 100 MHz
- rst_n  in  1  asynchronous active-low reset
- row  in  4  keypad row inputs, active-low, bit3=R1 .. bit0=R4
- col  out  4  keypad column drive, active-low one-cold, bit3=C1 .. bit0=C4
- sel_num  in  1  target operand: 0=num1, 1=num2; latched at first digit of an entry
- clear  in  1  synchronous abort of the current entry
- key_valid  out  1  one-cycle pulse per accepted key press
- key_code  out  4  hex code of the last accepted key
- entry  out  16  digits entered so far, newest digit in [3:0]
- digit_cnt  out  3  digits entered in the current entry, 0..3
- num1  out  16  committed operand 1
- num2  out  16  committed operand 2
- num_done  out  1  one-cycle pulse when num1 or num2 is updated
- num_sel_q  out  1  operand selected by the current or most recent entry

Behaviour:
- Reset (async assert, sync release): col=4'b1111; all counters, key_code, entry, digit_cnt, num1, num2 and num_sel_q = 0; key_valid and num_done = 0; debouncer in RELEASED state.
- Scan FSM states: IDLE, then DRIVE_C1..C4.
  - IDLE lasts one cycle after reset, then enters DRIVE_C1.
  - Each DRIVE_Ck drives col low on Ck only, for exactly SETTLE_CYCLES cycles.
  - row is sampled on the last cycle of the window, then the FSM moves to the next column. C4 wraps to C1.
  - Sweep period = 4*SETTLE_CYCLES cycles.
- Key map, row R1..R4 per column:
  - C1: 1, 4, 7, F
  - C2: 2, 5, 8, 0
  - C3: 3, 6, 9, E
  - C4: A, B, C, D
- Sweep result, evaluated at the C4 sample:
  - Exactly one key low across all four samples: that code.
  - Zero keys low: NONE.
  - More than one key low (per column or across columns): INVALID, treated as NONE for release and ignored for press.
- Debouncer states: RELEASED, PRESSED.
  - RELEASED to PRESSED: same code in DEBOUNCE_SWEEPS consecutive sweeps. A different code restarts the count at 1.
  - On that transition: key_valid=1 for one cycle, the cycle after the C4 sample; key_code updated in the same cycle.
  - PRESSED to RELEASED: NONE/INVALID in DEBOUNCE_SWEEPS consecutive sweeps.
  - Holding a key never repeats key_valid. Changing keys without a release is ignored.
- Entry sequencer, on key_valid:
  - entry <= {entry[11:0], key_code}.
  - If digit_cnt==0, latch num_sel_q <= sel_num.
  - If digit_cnt<3: digit_cnt increments.
  - If digit_cnt==3: the next cycle writes {entry[11:0], key_code} to num1 (num_sel_q=0) or num2 (num_sel_q=1), pulses num_done, and clears digit_cnt to 0. entry keeps the committed value until the next key.
- sel_num changes mid-entry have no effect until the next entry begins.
- clear: entry=0, digit_cnt=0; num1/num2 unchanged. Clear wins over a simultaneous key_valid (that key is discarded). Clear during the commit cycle still commits.
- Reset mid-scan or mid-entry: immediate return to reset values; any partial entry is lost.

Test Plan (SETTLE_CYCLES=8, DEBOUNCE_SWEEPS=2):
- Column drive: no key, run 3 sweeps -> col cycles 0111, 1011, 1101, 1110, each held exactly 8 cycles; key_valid never asserts.
- Single key: hold R2 low only while C3 is driven (key 6) for 2 sweeps -> one key_valid pulse with key_code=6, one cycle after the 2nd C4 sample; held 10 more sweeps -> no further pulse.
- Commit to num2: sel_num=1; press/release keys A, 1, 0, F -> entry steps 000A, 00A1, 0A10, A10F; num2=16'hA10F; num_done pulses once; num1 stays 0; num_sel_q=1.
- Invalid/bounce: hold key 5 for 1 sweep, then release -> no key_valid. Hold keys 1 and 2 together for 4 sweeps -> no key_valid.
- Clear and select latch: sel_num=0, enter 3, 7; set sel_num=1; assert clear in the same cycle as the key_valid for 9 -> entry=0, digit_cnt=0. Then enter 1, 2, 3, 4 -> num2=16'h1234 (sel re-latched at the new first digit).
- Reset mid-entry: after 2 digits, pulse rst_n low asynchronously -> col=1111, entry=0, num1=num2=0 immediately; scan restarts at C1 after release.

Source files
------------

// File: rtl/keypad_entry_controller.sv
`timescale 1ns/1ps
// keypad_entry_controller
// Scans a 4x4 active-low hex keypad one column at a time, debounces whole
// sweeps, and shifts accepted digits into a 4-digit entry that commits to
// operand num1 or num2.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   row   [3:0]   keypad rows, active-low, bit3=R1 .. bit0=R4
//   col   [3:0]   column drive, active-low one-cold, bit3=C1 .. bit0=C4
//   sel_num       target operand for the next entry (0=num1, 1=num2)
//   clear         abort the current entry
//   key_valid     one-cycle pulse per accepted press
//   key_code[3:0] last accepted key
//   entry  [15:0] digits entered so far, newest in [3:0]
//   digit_cnt[2:0] digits in the current entry (0..3)
//   num1, num2    committed operands
//   num_done      one-cycle pulse when num1/num2 is written
//   num_sel_q     operand latched by the current/most recent entry
module keypad_entry_controller #(
   parameter int unsigned SETTLE_CYCLES   = 100000,
   parameter int unsigned DEBOUNCE_SWEEPS = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  row,
   output logic [3:0]  col,
   input  logic        sel_num,
   input  logic        clear,
   output logic        key_valid,
   output logic [3:0]  key_code,
   output logic [15:0] entry,
   output logic [2:0]  digit_cnt,
   output logic [15:0] num1,
   output logic [15:0] num2,
   output logic        num_done,
   output logic        num_sel_q
);

   localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int unsigned DW = $clog2(DEBOUNCE_SWEEPS + 1);
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
   localparam logic [DW-1:0] DB_TARGET   = DW'(DEBOUNCE_SWEEPS);

   typedef enum logic [2:0] {S_IDLE, S_C1, S_C2, S_C3, S_C4} scan_e;
   typedef enum logic {DB_RELEASED, DB_PRESSED} db_e;

   scan_e         r_scan, w_scan_nxt, w_scan_adv;
   logic [SW-1:0] r_settle, w_settle_nxt;
   logic [3:0]    r_col, w_col_nxt;
   logic [1:0]    w_col_idx;
   logic          w_sample;

   db_e           r_db, w_db_nxt;
   logic [DW-1:0] r_db_cnt, w_db_cnt_nxt, w_cnt_inc;
   logic [3:0]    r_db_code, w_db_code_nxt;
   logic          w_accept;

   logic [1:0]    r_acc_n;
   logic [3:0]    r_acc_code;
   logic [3:0]    w_row_low;
   logic [1:0]    w_row_n, w_row_idx, w_base_n, w_sum_n;
   logic [2:0]    w_sum3;
   logic [3:0]    w_key, w_base_code, w_sum_code;
   logic          w_sweep_done, w_sweep_key;

   logic          r_key_valid;
   logic [3:0]    r_key_code;
   logic [15:0]   r_entry, r_num1, r_num2;
   logic [2:0]    r_digit_cnt;
   logic          r_num_done, r_sel, r_commit;

   // Key legend: column index C1..C4, row index R1..R4
   function automatic logic [3:0] f_key_map(input logic [1:0] c, input logic [1:0] r);
      logic [3:0] k;
      k = 4'h0;
      case ({c, r})
         4'h0: k = 4'h1;  4'h1: k = 4'h4;  4'h2: k = 4'h7;  4'h3: k = 4'hF;
         4'h4: k = 4'h2;  4'h5: k = 4'h5;  4'h6: k = 4'h8;  4'h7: k = 4'h0;
         4'h8: k = 4'h3;  4'h9: k = 4'h6;  4'hA: k = 4'h9;  4'hB: k = 4'hE;
         4'hC: k = 4'hA;  4'hD: k = 4'hB;  4'hE: k = 4'hC;  4'hF: k = 4'hD;
         default: k = 4'h0;
      endcase
      return k;
   endfunction

   // Scan FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_scan   <= S_IDLE;
         r_settle <= '0;
         r_col    <= 4'b1111;
      end else begin
         r_scan   <= w_scan_nxt;
         r_settle <= w_settle_nxt;
         r_col    <= w_col_nxt;
      end
   end

   // Scan FSM: next state, settle counter, sample strobe
   always_comb begin
      w_scan_nxt   = r_scan;
      w_settle_nxt = r_settle;
      w_scan_adv   = S_C1;
      w_col_idx    = 2'd0;
      w_sample     = 1'b0;
      w_col_nxt    = 4'b1111;
      case (r_scan)
         S_C1:    begin w_scan_adv = S_C2; w_col_idx = 2'd0; end
         S_C2:    begin w_scan_adv = S_C3; w_col_idx = 2'd1; end
         S_C3:    begin w_scan_adv = S_C4; w_col_idx = 2'd2; end
         S_C4:    begin w_scan_adv = S_C1; w_col_idx = 2'd3; end
         default: ;
      endcase
      if (r_scan == S_IDLE) begin
         w_scan_nxt   = S_C1;
         w_settle_nxt = '0;
      end else if (r_settle == SETTLE_LAST) begin
         w_sample     = 1'b1;
         w_settle_nxt = '0;
         w_scan_nxt   = w_scan_adv;
      end else begin
         w_settle_nxt = r_settle + SW'(1);
      end
      case (w_scan_nxt)
         S_C1:    w_col_nxt = 4'b0111;
         S_C2:    w_col_nxt = 4'b1011;
         S_C3:    w_col_nxt = 4'b1101;
         S_C4:    w_col_nxt = 4'b1110;
         default: w_col_nxt = 4'b1111;
      endcase
   end

   // Per-column row decode: 0, 1 (with row index) or 2 meaning "several"
   assign w_row_low = ~row;
   always_comb begin
      w_row_n   = 2'd2;
      w_row_idx = 2'd0;
      case (w_row_low)
         4'b0000: w_row_n = 2'd0;
         4'b1000: begin w_row_n = 2'd1; w_row_idx = 2'd0; end
         4'b0100: begin w_row_n = 2'd1; w_row_idx = 2'd1; end
         4'b0010: begin w_row_n = 2'd1; w_row_idx = 2'd2; end
         4'b0001: begin w_row_n = 2'd1; w_row_idx = 2'd3; end
         default: ;
      endcase
   end

   // Sweep accumulation; C1 starts a fresh sweep, C4 closes it
   assign w_key       = f_key_map(w_col_idx, w_row_idx);
   assign w_base_n    = (w_col_idx == 2'd0) ? 2'd0 : r_acc_n;
   assign w_base_code = (w_col_idx == 2'd0) ? 4'h0 : r_acc_code;
   assign w_sum3      = 3'(w_base_n) + 3'(w_row_n);
   assign w_sum_n     = (w_sum3 >= 3'd2) ? 2'd2 : w_sum3[1:0];
   assign w_sum_code  = (w_base_n == 2'd0) ? w_key : w_base_code;
   assign w_sweep_done = w_sample && (w_col_idx == 2'd3);
   assign w_sweep_key  = (w_sum_n == 2'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc_n    <= 2'd0;
         r_acc_code <= 4'h0;
      end else if (w_sample) begin
         r_acc_n    <= w_sum_n;
         r_acc_code <= w_sum_code;
      end
   end

   // Debouncer FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_db      <= DB_RELEASED;
         r_db_cnt  <= '0;
         r_db_code <= 4'h0;
      end else begin
         r_db      <= w_db_nxt;
         r_db_cnt  <= w_db_cnt_nxt;
         r_db_code <= w_db_code_nxt;
      end
   end

   // Debouncer FSM: decisions are taken once per sweep at the C4 sample
   assign w_cnt_inc = r_db_cnt + DW'(1);
   always_comb begin
      w_db_nxt      = r_db;
      w_db_cnt_nxt  = r_db_cnt;
      w_db_code_nxt = r_db_code;
      w_accept      = 1'b0;
      if (w_sweep_done) begin
         case (r_db)
            DB_RELEASED: begin
               if (w_sweep_key) begin
                  w_db_code_nxt = w_sum_code;
                  if ((r_db_cnt != '0) && (w_sum_code == r_db_code)) begin
                     w_db_cnt_nxt = w_cnt_inc;
                  end else begin
                     w_db_cnt_nxt = DW'(1);
                  end
                  if (w_db_cnt_nxt == DB_TARGET) begin
                     w_db_nxt     = DB_PRESSED;
                     w_db_cnt_nxt = '0;
                     w_accept     = 1'b1;
                  end
               end else begin
                  w_db_cnt_nxt = '0;
               end
            end
            DB_PRESSED: begin
               // Any key seen (even a different one) holds the press
               if (!w_sweep_key) begin
                  w_db_cnt_nxt = w_cnt_inc;
                  if (w_cnt_inc == DB_TARGET) begin
                     w_db_nxt     = DB_RELEASED;
                     w_db_cnt_nxt = '0;
                  end
               end else begin
                  w_db_cnt_nxt = '0;
               end
            end
            default: w_db_nxt = DB_RELEASED;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_key_valid <= 1'b0;
         r_key_code  <= 4'h0;
      end else begin
         r_key_valid <= w_accept;
         if (w_accept) r_key_code <= w_sum_code;
      end
   end

   // Entry sequencer; commit lands the cycle after the 4th digit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_entry     <= 16'h0;
         r_digit_cnt <= 3'd0;
         r_num1      <= 16'h0;
         r_num2      <= 16'h0;
         r_num_done  <= 1'b0;
         r_sel       <= 1'b0;
         r_commit    <= 1'b0;
      end else begin
         r_num_done <= 1'b0;
         if (r_commit) begin
            if (r_sel) r_num2 <= r_entry;
            else       r_num1 <= r_entry;
            r_num_done  <= 1'b1;
            r_digit_cnt <= 3'd0;
            r_commit    <= 1'b0;
         end
         if (clear) begin
            r_entry     <= 16'h0;
            r_digit_cnt <= 3'd0;
         end else if (r_key_valid) begin
            r_entry <= {r_entry[11:0], r_key_code};
            if (r_digit_cnt == 3'd0) r_sel <= sel_num;
            if (r_digit_cnt == 3'd3) r_commit    <= 1'b1;
            else                     r_digit_cnt <= r_digit_cnt + 3'd1;
         end
      end
   end

   assign col       = r_col;
   assign key_valid = r_key_valid;
   assign key_code  = r_key_code;
   assign entry     = r_entry;
   assign digit_cnt = r_digit_cnt;
   assign num1      = r_num1;
   assign num2      = r_num2;
   assign num_done  = r_num_done;
   assign num_sel_q = r_sel;

endmodule

// File: tb/tb_keypad_entry_controller.sv
`timescale 1ns/1ps
// Directed bench for keypad_entry_controller with a small keypad model that
// pulls rows low according to the driven column and the set of held keys.
module tb_keypad_entry_controller;

   localparam int unsigned SETTLE = 8;
   localparam int unsigned DEB    = 2;

   // Key legend per column C1..C4, rows R1..R4
   localparam logic [3:0] KEYMAP [0:3][0:3] = '{
      '{4'h1, 4'h4, 4'h7, 4'hF},
      '{4'h2, 4'h5, 4'h8, 4'h0},
      '{4'h3, 4'h6, 4'h9, 4'hE},
      '{4'hA, 4'hB, 4'hC, 4'hD}};

   logic        clk;
   logic        rst_n;
   logic [3:0]  row;
   logic [3:0]  col;
   logic        sel_num;
   logic        clear;
   logic        key_valid;
   logic [3:0]  key_code;
   logic [15:0] entry;
   logic [2:0]  digit_cnt;
   logic [15:0] num1;
   logic [15:0] num2;
   logic        num_done;
   logic        num_sel_q;

   logic [15:0] pressed;
   int          n_checks;
   int          n_pass;
   int          kv_cnt;
   int          nd_cnt;

   keypad_entry_controller #(
      .SETTLE_CYCLES   (SETTLE),
      .DEBOUNCE_SWEEPS (DEB)
   ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .row       (row),
      .col       (col),
      .sel_num   (sel_num),
      .clear     (clear),
      .key_valid (key_valid),
      .key_code  (key_code),
      .entry     (entry),
      .digit_cnt (digit_cnt),
      .num1      (num1),
      .num2      (num2),
      .num_done  (num_done),
      .num_sel_q (num_sel_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Keypad model
   always_comb begin
      row = 4'hF;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            if (col[3-c] == 1'b0 && pressed[KEYMAP[c][r]]) row[3-r] = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (key_valid) kv_cnt <= kv_cnt + 1;
         if (num_done)  nd_cnt <= nd_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else             n_pass++;
   endtask

   // mode 0: plain press; 1: clear with key_valid; 2: clear in commit cycle
   task automatic press_key(input logic [3:0] code, input int mode, input logic [15:0] exp_entry);
      int t;
      pressed = 16'h0001 << code;
      t = 0;
      while (!key_valid && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("kv_seen", 32'(key_valid), 32'd1);
      chk("key_code", 32'(key_code), 32'(code));
      if (mode == 1) clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      if (mode == 2) begin
         clear = 1'b1;
         @(negedge clk);
         clear = 1'b0;
      end
      chk("entry", 32'(entry), 32'(exp_entry));
      pressed = 16'h0;
      repeat (96) @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] exp_col [0:3];
      int hit;
      int kv0;
      int nd0;
      exp_col[0] = 4'b0111; exp_col[1] = 4'b1011;
      exp_col[2] = 4'b1101; exp_col[3] = 4'b1110;
      n_checks = 0; n_pass = 0; kv_cnt = 0; nd_cnt = 0;
      rst_n = 1'b0; sel_num = 1'b0; clear = 1'b0; pressed = 16'h0;

      repeat (3) @(negedge clk);
      chk("rst_col", 32'(col), 32'hF);
      chk("rst_kv", 32'(key_valid), 32'd0);
      chk("rst_code", 32'(key_code), 32'd0);
      chk("rst_entry", 32'(entry), 32'd0);
      chk("rst_dcnt", 32'(digit_cnt), 32'd0);
      chk("rst_num1", 32'(num1), 32'd0);
      chk("rst_num2", 32'(num2), 32'd0);
      chk("rst_done", 32'(num_done), 32'd0);
      chk("rst_sel", 32'(num_sel_q), 32'd0);
      rst_n = 1'b1;

      // Column drive: 3 sweeps, each column exactly 8 cycles
      for (int k = 0; k < 96; k++) begin
         @(negedge clk);
         chk("col_seq", 32'(col), 32'(exp_col[(k / 8) % 4]));
      end
      chk("no_kv_idle", 32'(kv_cnt), 32'd0);

      // Key 6: pulse one cycle after the 2nd C4 sample that sees it
      pressed = 16'h0040;
      hit = 0;
      for (int i = 1; i <= 70; i++) begin
         @(negedge clk);
         if (key_valid && hit == 0) hit = i;
      end
      chk("kv_latency", 32'(hit), 32'd65);
      chk("key6_code", 32'(key_code), 32'h6);
      chk("key6_once", 32'(kv_cnt), 32'd1);
      repeat (320) @(negedge clk);
      chk("hold_norep", 32'(kv_cnt), 32'd1);
      pressed = 16'h0;
      repeat (96) @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      chk("clr_entry", 32'(entry), 32'd0);
      chk("clr_dcnt", 32'(digit_cnt), 32'd0);

      // Commit to num2
      sel_num = 1'b1;
      nd0 = nd_cnt;
      press_key(4'hA, 0, 16'h000A);
      press_key(4'h1, 0, 16'h00A1);
      press_key(4'h0, 0, 16'h0A10);
      press_key(4'hF, 0, 16'hA10F);
      chk("c2_num2", 32'(num2), 32'hA10F);
      chk("c2_num1", 32'(num1), 32'd0);
      chk("c2_done", 32'(nd_cnt - nd0), 32'd1);
      chk("c2_sel", 32'(num_sel_q), 32'd1);
      chk("c2_dcnt", 32'(digit_cnt), 32'd0);

      // Bounce and invalid multi-key
      kv0 = kv_cnt;
      pressed = 16'h0020;
      repeat (32) @(negedge clk);
      pressed = 16'h0;
      repeat (96) @(negedge clk);
      chk("bounce", 32'(kv_cnt - kv0), 32'd0);
      pressed = 16'h0006;
      repeat (128) @(negedge clk);
      pressed = 16'h0;
      repeat (96) @(negedge clk);
      chk("multikey", 32'(kv_cnt - kv0), 32'd0);
      chk("inv_entry", 32'(entry), 32'hA10F);

      // Clear wins over key 9; selection re-latched at next first digit
      sel_num = 1'b0;
      press_key(4'h3, 0, 16'h10F3);
      chk("sel_lat0", 32'(num_sel_q), 32'd0);
      press_key(4'h7, 0, 16'h0F37);
      chk("dcnt2", 32'(digit_cnt), 32'd2);
      sel_num = 1'b1;
      press_key(4'h9, 1, 16'h0000);
      chk("clr_dcnt9", 32'(digit_cnt), 32'd0);
      press_key(4'h1, 0, 16'h0001);
      sel_num = 1'b0;
      press_key(4'h2, 0, 16'h0012);
      press_key(4'h3, 0, 16'h0123);
      press_key(4'h4, 0, 16'h1234);
      chk("sel_num2", 32'(num2), 32'h1234);
      chk("sel_num1", 32'(num1), 32'd0);
      chk("sel_q1", 32'(num_sel_q), 32'd1);

      // Clear in the commit cycle still commits
      nd0 = nd_cnt;
      press_key(4'h5, 0, 16'h2345);
      press_key(4'h6, 0, 16'h3456);
      press_key(4'h7, 0, 16'h4567);
      press_key(4'h8, 2, 16'h0000);
      chk("cc_num1", 32'(num1), 32'h5678);
      chk("cc_num2", 32'(num2), 32'h1234);
      chk("cc_done", 32'(nd_cnt - nd0), 32'd1);
      chk("cc_dcnt", 32'(digit_cnt), 32'd0);

      // Reset mid-entry
      press_key(4'hB, 0, 16'h000B);
      press_key(4'hC, 0, 16'h00BC);
      chk("pre_rst_dcnt", 32'(digit_cnt), 32'd2);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_col", 32'(col), 32'hF);
      chk("arst_entry", 32'(entry), 32'd0);
      chk("arst_num1", 32'(num1), 32'd0);
      chk("arst_num2", 32'(num2), 32'd0);
      chk("arst_dcnt", 32'(digit_cnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         chk("restart_col", 32'(col), 32'(exp_col[k / 8]));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
